cordic_pipe_mv: RTL and testbench

//   Parametrised pipelined CORDIC engine with per-sample mode. ROTATION mode turns a phase word into cos/sin.

---
 rtl/cordic_pipe_mv_if.sv | 31 +++
 rtl/cordic_pipe_mv.sv | 166 ++++++++++++++++
 tb/tb_cordic_pipe_mv.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pipe_mv_if.sv
// Sample bus for the dual-mode CORDIC pipeline: input handshake, output handshake, payload and tag.
interface cordic_pipe_mv_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 18,
  parameter int unsigned TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [DATA_WIDTH-1:0] in_phase;
  logic [DATA_WIDTH-1:0] in_x;
  logic [DATA_WIDTH-1:0] in_y;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_mode;
  logic [OUT_WIDTH-1:0]  out_x;
  logic [OUT_WIDTH-1:0]  out_y;
  logic [DATA_WIDTH-1:0] out_z;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, in_mode, in_phase, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_mode, out_x, out_y, out_z, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_phase, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_mode, out_x, out_y, out_z, out_tag
  );
endinterface

// File: rtl/cordic_pipe_mv.sv
// Pipelined CORDIC: per-sample rotation (phase -> cos/sin) or vectoring ((x,y) -> magnitude*K, atan2).
// One pre-rotation stage, ITER micro-rotation stages, one saturating output stage; global stall on ce.
module cordic_pipe_mv #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 18,
  parameter int unsigned ITER       = 30,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input logic            clk,
  input logic            rst,
  cordic_pipe_mv_if.slave bus
);
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned OW   = OUT_WIDTH;
  localparam int unsigned IW   = DW + 2;
  localparam int unsigned DROP = 32 - DW;
  localparam int unsigned XSH  = 34 - DW;

  // 1/K in Q0.32; the rotation seed is round(2^(DW-2)/K)
  localparam logic [31:0] INV_K = 32'h9B74EDA8;
  localparam logic [32:0] X0_RAW = {INV_K, 1'b0} + (33'd1 << XSH);
  localparam logic signed [IW-1:0] X0 = IW'(X0_RAW >> (XSH + 1));

  // atan(2^-i) in full-turn units of 2^32
  localparam logic [31:0] ATAN32 [0:29] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43,
    32'h0145D7E1, 32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F,
    32'h000A2F98, 32'h000517CC, 32'h00028BE6, 32'h000145F3, 32'h0000A2FA,
    32'h0000517D, 32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051, 32'h00000029,
    32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001
  };

  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  // Round a 32-bit full-turn angle to DW bits
  function automatic logic [DW-1:0] theta(input int unsigned i);
    logic [33:0] r;
    r = {1'b0, ATAN32[5'(i)], 1'b0} + (34'd1 << DROP);
    return DW'(r >> (DROP + 1));
  endfunction

  // Floor to bits [DW-1 -: OW], saturating when the dropped high bits are not sign copies
  function automatic logic signed [OW-1:0] trunc_sat(input logic signed [IW-1:0] v);
    logic [IW-DW:0] hi;
    hi = v[IW-1:DW-1];
    if ((hi == '0) || (&hi)) return v[DW-1 -: OW];
    return v[IW-1] ? OMIN : OMAX;
  endfunction

  function automatic logic signed [OW-1:0] neg_sat(input logic signed [OW-1:0] v);
    return (v == OMIN) ? OMAX : -v;
  endfunction

  logic                  ce;
  logic                  vld  [0:ITER];
  logic                  mode [0:ITER];
  logic [1:0]            quad [0:ITER];
  logic [TAG_WIDTH-1:0]  tag  [0:ITER];
  logic signed [IW-1:0]  xs   [0:ITER];
  logic signed [IW-1:0]  ys   [0:ITER];
  logic [DW-1:0]         zs   [0:ITER];

  logic signed [IW-1:0]  vx, vy, x0n, y0n;
  logic [DW-1:0]         z0n;
  logic [1:0]            q0n;
  logic signed [OW-1:0]  tx, ty, ox, oy;

  assign ce           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = ce;

  // Pre-rotation: quadrant fold for rotation, half-plane fold for vectoring
  always_comb begin
    vx  = IW'($signed(bus.in_x));
    vy  = IW'($signed(bus.in_y));
    q0n = '0;
    x0n = X0;
    y0n = '0;
    z0n = {2'b00, bus.in_phase[DW-3:0]};
    if (bus.in_mode) begin
      if (vx[IW-1]) begin
        x0n = -vx;
        y0n = -vy;
        z0n = {1'b1, {(DW-1){1'b0}}};
      end else begin
        x0n = vx;
        y0n = vy;
        z0n = '0;
      end
    end else begin
      q0n = bus.in_phase[DW-1:DW-2];
    end
  end

  // Stage valids; cleared by reset so in-flight samples are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= ITER; i++) vld[i] <= 1'b0;
    end else if (ce) begin
      vld[0] <= bus.in_valid;
      for (int unsigned i = 0; i < ITER; i++) vld[i+1] <= vld[i];
    end
  end

  // Datapath: stage 0 captures the pre-rotated sample, stages 1..ITER micro-rotate
  always_ff @(posedge clk) begin
    if (ce) begin
      xs[0]   <= x0n;
      ys[0]   <= y0n;
      zs[0]   <= z0n;
      quad[0] <= q0n;
      mode[0] <= bus.in_mode;
      tag[0]  <= bus.in_tag;
      for (int unsigned i = 0; i < ITER; i++) begin
        mode[i+1] <= mode[i];
        quad[i+1] <= quad[i];
        tag[i+1]  <= tag[i];
        if (mode[i] ? ys[i][IW-1] : ~zs[i][DW-1]) begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
          zs[i+1] <= zs[i] - theta(i);
        end else begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
          zs[i+1] <= zs[i] + theta(i);
        end
      end
    end
  end

  // Output scaling and quadrant unfold for rotation samples
  always_comb begin
    tx = trunc_sat(xs[ITER]);
    ty = trunc_sat(ys[ITER]);
    ox = tx;
    oy = ty;
    if (!mode[ITER]) begin
      unique case (quad[ITER])
        2'd1:    begin ox = neg_sat(ty); oy = tx;          end
        2'd2:    begin ox = neg_sat(tx); oy = neg_sat(ty); end
        2'd3:    begin ox = ty;          oy = neg_sat(tx); end
        default: ;
      endcase
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_mode  <= 1'b0;
      bus.out_tag   <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_z     <= '0;
    end else if (ce) begin
      bus.out_valid <= vld[ITER];
      bus.out_mode  <= mode[ITER];
      bus.out_tag   <= tag[ITER];
      bus.out_x     <= ox;
      bus.out_y     <= oy;
      bus.out_z     <= zs[ITER];
    end
  end
endmodule

// File: tb/tb_cordic_pipe_mv.sv
// Bench for cordic_pipe_mv: directed table, streaming, random backpressure, phase sweep, reset mid-stream.
module tb_cordic_pipe_mv;
  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 18;
  localparam int unsigned IT  = 30;
  localparam int unsigned TW  = 4;
  localparam int          LAT = IT + 2;
  localparam real KG    = 1.6467602581;
  localparam real TWO32 = 4294967296.0;
  localparam real TPI   = 6.283185307179586;
  localparam real FS    = 65536.0;
  localparam real OSAT  = 131071.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_pipe_mv_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .TAG_WIDTH(TW)) bus ();
  cordic_pipe_mv #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .ITER(IT), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string         name;
    logic          mode;
    logic [31:0]   phase;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [TW-1:0] tag;
    real           ex;
    real           ey;
    real           ez;
    bit            chk_z;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   first_acc = -1, first_out = -1, last_out = -1, n_out = 0;
  bit   rnd_ready = 1'b0;
  bit   hold_chk  = 1'b0;
  logic [OW-1:0] px, py;
  logic [DW-1:0] pz;
  logic [TW-1:0] ptag;
  logic          pmode;

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic rec_t mk(input string n, input logic m, input logic [31:0] ph,
                              input logic [31:0] x, input logic [31:0] y,
                              input real ex, input real ey, input real ez, input bit cz);
    rec_t r;
    r.name = n; r.mode = m; r.phase = ph; r.x = x; r.y = y; r.tag = TW'(0);
    r.ex = ex; r.ey = ey; r.ez = ez; r.chk_z = cz;
    return r;
  endfunction

  // Reference: trig from the phase, or Euclidean magnitude/atan2 from (x,y)
  function automatic rec_t model(input rec_t r);
    real a, fx, fy, m;
    if (!r.mode) begin
      a = real'(r.phase) / TWO32 * TPI;
      r.ex = $floor($cos(a) * FS);
      r.ey = $floor($sin(a) * FS);
      r.ez = 0.0;
      r.chk_z = 1'b1;
    end else begin
      fx = real'($signed(r.x));
      fy = real'($signed(r.y));
      m = $floor($sqrt(fx * fx + fy * fy) * KG / 16384.0);
      if (m > OSAT) m = OSAT;
      r.ex = m;
      r.ey = 0.0;
      r.chk_z = (r.x != 0) || (r.y != 0);
      a = $atan2(fy, fx) / TPI * TWO32;
      if (a < 0.0) a = a + TWO32;
      r.ez = a;
    end
    return r;
  endfunction

  task automatic check_out();
    rec_t r;
    real gx, gy, dz;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_output tag=%0d got_x=%0d", bus.out_tag, $signed(bus.out_x));
      return;
    end
    r  = exp_q.pop_front();
    gx = real'($signed(bus.out_x));
    gy = real'($signed(bus.out_y));
    total++;
    if (bus.out_mode !== r.mode || bus.out_tag !== r.tag) begin
      bad++;
      $display("FAIL %s mode/tag got=%b/%0d want=%b/%0d", r.name, bus.out_mode, bus.out_tag, r.mode, r.tag);
    end
    total++;
    if (rabs(gx - r.ex) > 2.0) begin
      bad++; $display("FAIL %s out_x got=%0d want=%0.0f", r.name, $signed(bus.out_x), r.ex);
    end
    total++;
    if (rabs(gy - r.ey) > 2.0) begin
      bad++; $display("FAIL %s out_y got=%0d want=%0.0f", r.name, $signed(bus.out_y), r.ey);
    end
    if (r.chk_z) begin
      dz = real'(bus.out_z) - r.ez;
      while (dz >= TWO32 / 2.0) dz = dz - TWO32;
      while (dz < -TWO32 / 2.0) dz = dz + TWO32;
      total++;
      if (rabs(dz) > 256.0) begin
        bad++; $display("FAIL %s out_z got=%h want=%h", r.name, bus.out_z, 32'($rtoi(r.ez / 2.0)) << 1);
      end
    end
  endtask

  // Monitor: handshake rule, stall stability, scoreboard, latency bookkeeping
  always @(negedge clk) begin
    cyc++;
    total++;
    if (bus.in_ready !== (bus.out_ready | ~bus.out_valid)) begin
      bad++; $display("FAIL in_ready got=%b want=%b", bus.in_ready, bus.out_ready | ~bus.out_valid);
    end
    if (hold_chk) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_x !== px || bus.out_y !== py || bus.out_z !== pz ||
          bus.out_tag !== ptag || bus.out_mode !== pmode) begin
        bad++; $display("FAIL stall_hold got_x=%0d want_x=%0d valid=%b", bus.out_x, px, bus.out_valid);
      end
    end
    hold_chk = bus.out_valid && !bus.out_ready && !rst;
    px = bus.out_x; py = bus.out_y; pz = bus.out_z; ptag = bus.out_tag; pmode = bus.out_mode;
    if (bus.in_valid && bus.in_ready && first_acc < 0) first_acc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
      check_out();
    end
  end

  // Downstream ready: held high or 50% random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input rec_t r);
    int w = 0;
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_mode = r.mode; bus.in_phase = r.phase;
    bus.in_x = r.x; bus.in_y = r.y; bus.in_tag = r.tag;
    while (!ok) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else if (++w > 1000) begin
        total++; bad++; $display("FAIL send_timeout %s got=0 want=1", r.name);
        bus.in_valid = 1'b0;
        return;
      end
      if (ok) exp_q.push_back(r);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int w = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 5000) begin @(posedge clk); #1; w++; end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain pending got=%0d want=0", exp_q.size()); end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic arm();
    first_acc = -1; first_out = -1; last_out = -1; n_out = 0;
  endtask

  function automatic rec_t rnd(input string n, input logic m, input logic [TW-1:0] t);
    rec_t r;
    r = mk(n, m, $urandom, $urandom, $urandom, 0.0, 0.0, 0.0, 1'b0);
    r.tag = t;
    return model(r);
  endfunction

  initial begin : main
    rec_t tbl[13];
    rec_t r;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_phase = '0;
    bus.in_x = '0; bus.in_y = '0; bus.in_tag = '0;

    tbl[0]  = mk("rot_0",     1'b0, 32'h00000000, 0, 0,  65536.0,      0.0, 0.0, 1'b1);
    tbl[1]  = mk("rot_90",    1'b0, 32'h40000000, 0, 0,      0.0,  65536.0, 0.0, 1'b1);
    tbl[2]  = mk("rot_270",   1'b0, 32'hC0000000, 0, 0,      0.0, -65536.0, 0.0, 1'b1);
    tbl[3]  = mk("rot_45",    1'b0, 32'h20000000, 0, 0,  46341.0,  46341.0, 0.0, 1'b1);
    tbl[4]  = mk("rot_q0end", 1'b0, 32'h3FFFFFFF, 0, 0,      0.0,  65535.0, 0.0, 1'b1);
    tbl[5]  = mk("rot_180",   1'b0, 32'h80000000, 0, 0, -65536.0,      0.0, 0.0, 1'b1);
    tbl[6]  = mk("vec_45",    1'b1, 0, 32'h10000000, 32'h10000000, 38156.0, 0.0, 536870912.0, 1'b1);
    tbl[7]  = mk("vec_negx",  1'b1, 0, 32'hF0000000, 32'h00000000, 26980.0, 0.0, 2147483648.0, 1'b1);
    tbl[8]  = mk("vec_sat45", 1'b1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, OSAT,    0.0, 536870912.0, 1'b1);
    tbl[9]  = mk("vec_minx",  1'b1, 0, 32'h80000000, 32'h00000000, OSAT,    0.0, 2147483648.0, 1'b1);
    tbl[10] = mk("vec_90",    1'b1, 0, 32'h00000000, 32'h10000000, 26980.0, 0.0, 1073741824.0, 1'b1);
    tbl[11] = mk("vec_zero",  1'b1, 0, 32'h00000000, 32'h00000000, 0.0,     0.0, 0.0, 1'b0);
    tbl[12] = mk("vec_m45",   1'b1, 0, 32'h10000000, 32'hF0000000, 38156.0, 0.0, 3758096384.0, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_mode !== 1'b0 || bus.out_tag !== '0) begin
      bad++; $display("FAIL reset_ctrl got=%b/%b/%0d want=0/0/0", bus.out_valid, bus.out_mode, bus.out_tag);
    end
    total++;
    if (bus.out_x !== '0 || bus.out_y !== '0 || bus.out_z !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.out_x, bus.out_y, bus.out_z);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, back to back
    for (int i = 0; i < 13; i++) begin
      tbl[i].tag = TW'(i);
      send(tbl[i]);
    end
    drain();

    // Stream of 100 alternating samples with full throughput
    arm();
    for (int i = 0; i < 100; i++) send(rnd("stream", 1'(i % 2), TW'(i % 16)));
    drain();
    total++;
    if (first_out - first_acc != LAT) begin
      bad++; $display("FAIL latency got=%0d want=%0d", first_out - first_acc, LAT);
    end
    total++;
    if (n_out != 100 || last_out - first_out != 99) begin
      bad++; $display("FAIL stream_bubbles got=%0d/%0d want=100/99", n_out, last_out - first_out);
    end

    // Random backpressure and input gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(rnd("random", 1'($urandom_range(0, 1)), TW'($urandom)));
      if ($urandom_range(0, 3) == 0) begin bus.in_valid = 1'b0; @(posedge clk); #1; end
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk); #1;

    // Rotation phase sweep
    for (int k = 0; k < 4096; k++) begin
      r = mk("sweep", 1'b0, 32'(k) << 20, 0, 0, 0.0, 0.0, 0.0, 1'b0);
      r.tag = TW'(k);
      send(model(r));
    end
    drain();

    // Reset with 20 samples in flight, then one fresh sample
    for (int i = 0; i < 20; i++) send(rnd("flight", 1'(i % 2), TW'(i)));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    arm();
    r = mk("post_rst", 1'b1, 0, 32'h10000000, 32'h10000000, 38156.0, 0.0, 536870912.0, 1'b1);
    r.tag = TW'(9);
    bus.in_valid = 1'b1; bus.in_mode = r.mode; bus.in_phase = r.phase;
    bus.in_x = r.x; bus.in_y = r.y; bus.in_tag = r.tag;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_x !== '0 || bus.out_y !== '0 || bus.out_z !== '0) begin
      bad++; $display("FAIL rst_flush got=%b/%h want=0/0", bus.out_valid, bus.out_x);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready);
    end
    if (bus.in_ready) exp_q.push_back(r);
    @(posedge clk); #1;
    drain();
    total++;
    if (first_out - first_acc != LAT || n_out != 1) begin
      bad++; $display("FAIL rst_latency got=%0d/%0d want=%0d/1", first_out - first_acc, n_out, LAT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
